// File: rtl/pipe_skid_buf.sv
// Pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.
// Upstream ready is registered, so no combinational ready path crosses stages.
// Also provides a synchronous flush and a saturating downstream-stall counter.
module pipe_skid_buf #(
  parameter int DATA_W     = 32,
  parameter bit CLEAR_DATA = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        count_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  // The encoding doubles as the occupancy reported on count_o.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             r_state;
  state_t             w_state_next;
  logic               r_in_ready;
  logic [DATA_W-1:0]  r_main_d;
  logic [DATA_W-1:0]  r_skid_d;
  logic [DATA_W-1:0]  w_main_d_next;
  logic [DATA_W-1:0]  w_skid_d_next;
  logic [CNT_W-1:0]   r_stall_cnt;
  logic               w_acc;
  logic               w_pop;
  logic               w_main_v;

  // The main entry is valid in BUSY and FULL. The skid entry is valid only in FULL.
  assign w_main_v    = (r_state != ST_EMPTY);
  assign w_acc       = in_valid_i && r_in_ready;
  assign w_pop       = w_main_v && out_ready_i;

  assign out_valid_o = w_main_v;
  assign out_data_o  = r_main_d;
  assign in_ready_o  = r_in_ready;
  assign count_o     = r_state;
  assign stall_cnt_o = r_stall_cnt;

  // Next-state and data-path selection. The skid entry only refills main and never bypasses it.
  always_comb begin
    w_state_next  = r_state;
    w_main_d_next = r_main_d;
    w_skid_d_next = r_skid_d;
    case (r_state)
      ST_EMPTY: begin
        if (w_acc) begin
          w_state_next  = ST_BUSY;
          w_main_d_next = in_data_i;
        end
      end
      ST_BUSY: begin
        if (w_acc && !w_pop) begin
          w_state_next  = ST_FULL;
          w_skid_d_next = in_data_i;
        end else if (!w_acc && w_pop) begin
          w_state_next  = ST_EMPTY;
        end else if (w_acc && w_pop) begin
          w_main_d_next = in_data_i;
        end
      end
      ST_FULL: begin
        // Ready is low here, so only a pop can change the state.
        if (w_pop) begin
          w_state_next  = ST_BUSY;
          w_main_d_next = r_skid_d;
        end
      end
      default: begin
        w_state_next = ST_EMPTY;
      end
    endcase
    // Flush empties the stage and drops this cycle's input beat. A concurrent pop still completes downstream.
    if (flush_i) begin
      w_state_next = ST_EMPTY;
      if (CLEAR_DATA) begin
        w_main_d_next = '0;
        w_skid_d_next = '0;
      end else begin
        w_main_d_next = r_main_d;
        w_skid_d_next = r_skid_d;
      end
    end
  end

  // State and registered ready. Ready stays low while in reset and rises on the first edge after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_in_ready <= (w_state_next != ST_FULL);
    end
  end

  // Payload registers. They are either cleared by reset or left untouched, depending on CLEAR_DATA.
  generate
    if (CLEAR_DATA) begin : g_data_clr
      // Payload registers with reset to zero.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          r_main_d <= '0;
          r_skid_d <= '0;
        end else begin
          r_main_d <= w_main_d_next;
          r_skid_d <= w_skid_d_next;
        end
      end
    end else begin : g_data_keep
      // Payload registers without reset. Their contents are meaningless while the valid bits are clear.
      always_ff @(posedge clk_i) begin
        r_main_d <= w_main_d_next;
        r_skid_d <= w_skid_d_next;
      end
    end
  endgenerate

  // Count cycles where a valid beat is held off by downstream, saturating at all-ones. Flush does not clear it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else if (w_main_v && !out_ready_i && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_skid_buf.sv
// Self-checking bench for pipe_skid_buf.
// A FIFO scoreboard tracks beats in flight. Per-scenario tasks check the specific behaviours.
module tb_pipe_skid_buf;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  count;
  logic [15:0] stall;

  logic        s_flush;
  logic        s_in_valid;
  logic        s_in_ready;
  logic [7:0]  s_in_data;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [7:0]  s_out_data;
  logic [1:0]  s_count;
  logic [2:0]  s_stall;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_popped = 0;
  logic [31:0] exp_q[$];
  logic        exp_ready = 1'b0;
  logic [15:0] exp_stall = '0;

  pipe_skid_buf #(.DATA_W(32), .CLEAR_DATA(1'b1), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .count_o(count), .stall_cnt_o(stall)
  );

  pipe_skid_buf #(.DATA_W(8), .CLEAR_DATA(1'b1), .CNT_W(3)) dut_sat (
    .clk_i(clk), .rst_i(rst), .flush_i(s_flush),
    .in_valid_i(s_in_valid), .in_ready_o(s_in_ready), .in_data_i(s_in_data),
    .out_valid_o(s_out_valid), .out_ready_i(s_out_ready), .out_data_o(s_out_data),
    .count_o(s_count), .stall_cnt_o(s_stall)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard. At each falling edge it checks the outputs against the model.
  // It then applies the pop, flush and accept that the next rising edge will perform.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        exp_ready = 1'b0;
        exp_stall = '0;
      end else begin
        n_checks += 4;
        if (out_valid !== (exp_q.size() != 0)) begin
          n_fail++;
          $display("FAIL sb_valid: out_valid=%b required=%b", out_valid, exp_q.size() != 0);
        end
        if (int'(count) != exp_q.size()) begin
          n_fail++;
          $display("FAIL sb_count: count=%0d required=%0d", count, exp_q.size());
        end
        if (in_ready !== exp_ready) begin
          n_fail++;
          $display("FAIL sb_ready: in_ready=%b required=%b", in_ready, exp_ready);
        end
        if (stall !== exp_stall) begin
          n_fail++;
          $display("FAIL sb_stall: stall=%0d required=%0d", stall, exp_stall);
        end
        if ((exp_q.size() != 0) && !out_ready && (exp_stall != 16'hFFFF)) exp_stall++;
        if ((exp_q.size() != 0) && out_ready) begin
          n_checks++;
          if (out_data !== exp_q[0]) begin
            n_fail++;
            $display("FAIL sb_data: out_data=%h required=%h", out_data, exp_q[0]);
          end
          void'(exp_q.pop_front());
          n_popped++;
        end
        if (flush) exp_q.delete();
        else if (in_valid && exp_ready) exp_q.push_back(in_data);
        exp_ready = (exp_q.size() != 2);
      end
    end
  endtask

  // Offer a beat and hold it until accepted, within a bounded number of cycles.
  task automatic send(input logic [31:0] v);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = v;
    for (int k = 0; k < 20 && !ok; k++) begin
      ok = in_ready;
      step();
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL send_timeout: beat %h accepted=%b required=1", v, ok);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    s_flush = 1'b0; s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    send(32'h33);
    repeat (2) step();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_checks += 5;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: out_valid=%b required=0", out_valid); end
    if (count !== 2'd0) begin n_fail++; $display("FAIL reset_count: count=%0d required=0", count); end
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: in_ready=%b required=0", in_ready); end
    if (stall !== 16'd0) begin n_fail++; $display("FAIL reset_stall: stall=%0d required=0", stall); end
    if (out_data !== 32'd0) begin n_fail++; $display("FAIL reset_data: out_data=%h required=0", out_data); end
    repeat (2) step();
  endtask

  task automatic test_startup();
    in_valid  = 1'b1;
    in_data   = 32'hA5A5A5A5;
    out_ready = 1'b1;
    rst = 1'b0;
    step();
    n_checks += 2;
    if (count !== 2'd0) begin n_fail++; $display("FAIL startup_first_edge: count=%0d required=0", count); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL startup_ready: in_ready=%b required=1", in_ready); end
    step();
    in_valid = 1'b0;
    n_checks += 2;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL startup_valid: out_valid=%b required=1", out_valid); end
    if (out_data !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL startup_data: out_data=%h required=a5a5a5a5", out_data); end
    repeat (2) step();
  endtask

  task automatic test_streaming();
    int p0;
    p0 = n_popped;
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      send(32'(i));
      n_checks += 2;
      if (count > 2'd1) begin n_fail++; $display("FAIL stream_count: count=%0d required<=1", count); end
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready: in_ready=%b required=1", in_ready); end
    end
    repeat (2) step();
    n_checks += 2;
    if (stall !== 16'd0) begin n_fail++; $display("FAIL stream_stall: stall=%0d required=0", stall); end
    if (n_popped - p0 != 16) begin n_fail++; $display("FAIL stream_pops: pops=%0d required=16", n_popped - p0); end
  endtask

  task automatic test_backpressure();
    int p0;
    p0 = n_popped;
    out_ready = 1'b1;
    send(32'h1);
    out_ready = 1'b0;
    send(32'h2);
    n_checks += 4;
    if (count !== 2'd2) begin n_fail++; $display("FAIL bp_count: count=%0d required=2", count); end
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready: in_ready=%b required=0", in_ready); end
    if (out_data !== 32'h1) begin n_fail++; $display("FAIL bp_head: out_data=%h required=1", out_data); end
    if (stall !== 16'd1) begin n_fail++; $display("FAIL bp_stall1: stall=%0d required=1", stall); end
    in_valid = 1'b1;
    in_data  = 32'h3;
    repeat (2) step();
    n_checks += 2;
    if (stall !== 16'd3) begin n_fail++; $display("FAIL bp_stall3: stall=%0d required=3", stall); end
    if (out_data !== 32'h1) begin n_fail++; $display("FAIL bp_hold: out_data=%h required=1", out_data); end
    out_ready = 1'b1;
    send(32'h3);
    send(32'h4);
    repeat (3) step();
    n_checks += 2;
    if (n_popped - p0 != 4) begin n_fail++; $display("FAIL bp_pops: pops=%0d required=4", n_popped - p0); end
    if (count !== 2'd0) begin n_fail++; $display("FAIL bp_drain: count=%0d required=0", count); end
  endtask

  task automatic test_flush();
    int p0;
    out_ready = 1'b1;
    send(32'h11);
    out_ready = 1'b0;
    send(32'h12);
    p0 = n_popped;
    n_checks++;
    if (count !== 2'd2) begin n_fail++; $display("FAIL flush_pre: count=%0d required=2", count); end
    in_valid = 1'b1;
    in_data  = 32'hDEAD;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    n_checks += 4;
    if (count !== 2'd0) begin n_fail++; $display("FAIL flush_count: count=%0d required=0", count); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: out_valid=%b required=0", out_valid); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: in_ready=%b required=1", in_ready); end
    if (out_data !== 32'd0) begin n_fail++; $display("FAIL flush_data: out_data=%h required=0", out_data); end
    out_ready = 1'b1;
    repeat (3) step();
    n_checks++;
    if (n_popped != p0) begin n_fail++; $display("FAIL flush_pops: pops=%0d required=0", n_popped - p0); end
  endtask

  task automatic test_back_to_back();
    int p0;
    out_ready = 1'b1;
    send(32'h7);
    p0 = n_popped;
    n_checks++;
    if (out_data !== 32'h7) begin n_fail++; $display("FAIL b2b_first: out_data=%h required=7", out_data); end
    send(32'h8);
    n_checks += 3;
    if (count !== 2'd1) begin n_fail++; $display("FAIL b2b_count: count=%0d required=1", count); end
    if (out_data !== 32'h8) begin n_fail++; $display("FAIL b2b_data: out_data=%h required=8", out_data); end
    if (n_popped - p0 != 1) begin n_fail++; $display("FAIL b2b_pops: pops=%0d required=1", n_popped - p0); end
    repeat (2) step();
  endtask

  task automatic test_saturation();
    s_out_ready = 1'b0;
    s_in_valid  = 1'b1;
    s_in_data   = 8'h5A;
    step();
    s_in_valid  = 1'b0;
    s_in_data   = 8'hFF;
    n_checks += 3;
    if (s_count !== 2'd1) begin n_fail++; $display("FAIL sat_count: count=%0d required=1", s_count); end
    if (s_out_data !== 8'h5A) begin n_fail++; $display("FAIL sat_data: out_data=%h required=5a", s_out_data); end
    if (s_stall !== 3'd0) begin n_fail++; $display("FAIL sat_stall0: stall=%0d required=0", s_stall); end
    repeat (5) step();
    n_checks++;
    if (s_stall !== 3'd5) begin n_fail++; $display("FAIL sat_stall5: stall=%0d required=5", s_stall); end
    repeat (5) step();
    n_checks += 3;
    if (s_stall !== 3'd7) begin n_fail++; $display("FAIL sat_stall7: stall=%0d required=7", s_stall); end
    if (s_out_valid !== 1'b1) begin n_fail++; $display("FAIL sat_valid: out_valid=%b required=1", s_out_valid); end
    if (s_out_data !== 8'h5A) begin n_fail++; $display("FAIL sat_stable: out_data=%h required=5a", s_out_data); end
    s_out_ready = 1'b1;
    step();
    n_checks += 2;
    if (s_count !== 2'd0) begin n_fail++; $display("FAIL sat_drain: count=%0d required=0", s_count); end
    if (s_stall !== 3'd7) begin n_fail++; $display("FAIL sat_hold: stall=%0d required=7", s_stall); end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    s_flush = 1'b0; s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0;
    fork
      monitor();
    join_none
    test_reset();
    test_startup();
    test_streaming();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_saturation();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_skid_buf.md
# pipe_skid_buf

Parametrised pipeline stage register with a full valid/ready handshake, a 2-entry skid buffer, synchronous flush and a saturating stall counter. It replaces the fixed-field, stall-only inter-stage buffers between IF/ID/EX/MEM/WB. The stage sustains one beat per cycle with registered in_ready_o, so no combinational ready path crosses stages. Callers pack stage fields (inst, operands, imm, register indices, op, valid) into one payload bus.

## Interface
- DATA_W, 32: payload width in bits (≥1).
- CLEAR_DATA, 1: 1 = data registers zeroed on reset and flush; 0 = data registers hold old contents (valid bits still cleared).
- CNT_W, 16: width of the stall counter.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  synchronous flush; empties the stage and drops that cycle's input beat.
- in_valid_i  in  1  upstream beat present.
- in_ready_o  out  1  stage can accept; registered.
- in_data_i  in  DATA_W  upstream payload.
- out_valid_o  out  1  out_data_o holds a valid beat.
- out_ready_i  in  1  downstream accepts; 0 = stall.
- out_data_o  out  DATA_W  payload; driven directly from the main register.
- count_o  out  2  occupancy, 0..2.
- stall_cnt_o  out  CNT_W  cycles with out_valid_o=1 && out_ready_i=0, saturating.

## Operation
- Storage is main register (main_v, main_d) and skid register (skid_v, skid_d). out_valid_o=main_v, out_data_o=main_d.
- acc = in_valid_i && in_ready_o; pop = out_valid_o && out_ready_i.
- States (count_o):
  - EMPTY (0):
    - acc → BUSY, main ← in.
  - BUSY (1):
    - acc && !pop → FULL, skid ← in, main holds.
    - !acc && pop → EMPTY.
    - acc && pop → BUSY, main ← in.
    - Neither → BUSY, hold.
  - FULL (2): in_ready_o=0, so acc is impossible.
    - pop → BUSY, main ← skid, skid_v ← 0.
    - No pop → hold.
- in_ready_o next value = (next state != FULL).
- FIFO order is preserved in every case. The skid entry never bypasses main.
- flush_i=1 overrides all transitions:
  - Next state is EMPTY; main_v and skid_v ← 0.
  - Input beat is dropped even if acc=1.
  - A pop in the same cycle still counts as consumed downstream.
  - in_ready_o ← 1.
  - If CLEAR_DATA=1, main_d and skid_d ← 0.
- stall_cnt_o:
  - +1 on each edge where out_valid_o && !out_ready_i.
  - Saturates at 2^CNT_W−1.
  - Cleared only by rst_i; flush does not clear it.
- Data moves only on acc or on a skid→main transfer. Values on in_data_i when acc=0 are ignored.

## Timing
- Reset (rst_i=1, immediate, asynchronous):
  - state=EMPTY, out_valid_o=0, count_o=0, stall_cnt_o=0.
  - in_ready_o=0.
  - out_data_o=0 if CLEAR_DATA=1, otherwise undefined.
- First rising edge after rst_i deasserts sets in_ready_o=1. A beat offered on that edge is not accepted.
- Latency: beat accepted on edge N appears on out_valid_o/out_data_o after edge N (visible in cycle N+1).
- Throughput: 1 beat/cycle while out_ready_i=1 continuously. Occupancy stays ≤1 and in_ready_o stays 1.
- When out_ready_i drops, at most one further beat is accepted, into skid. in_ready_o falls on the same edge.
- When out_ready_i rises in FULL, in_ready_o returns to 1 one edge later. There is no bubble on the output side.
- out_valid_o, once 1, stays 1 with stable out_data_o until pop or flush.
- Reset mid-operation discards both entries with no output beat. Flush behaves the same, but synchronously.

## Test plan
- Reset/startup:
  - Assert rst_i mid-cycle → outputs go to reset values immediately.
  - Deassert; hold in_valid_i=1, data 0xA5A5A5A5 → beat not accepted on the first edge, accepted on the second; out_valid_o=1 with 0xA5A5A5A5 one cycle later.
- Streaming: send 0x1..0x10 back-to-back with out_ready_i=1 → output 0x1..0x10 in order, one per cycle, count_o ≤1, in_ready_o constant 1, stall_cnt_o=0.
- Backpressure:
  - Stream 0x1..0x4 and drop out_ready_i while 0x1 is on output → 0x2 lands in skid, count_o=2, in_ready_o=0.
  - Hold 3 cycles → stall_cnt_o=3.
  - Raise out_ready_i → output 0x1,0x2,0x3,0x4 with no loss or duplication.
- Flush in FULL with in_valid_i=1, data 0xDEAD → next cycle count_o=0, out_valid_o=0, in_ready_o=1, out_data_o=0 (CLEAR_DATA=1); 0xDEAD never appears.
- Simultaneous accept+pop in BUSY: main=0x7, push 0x8 with out_ready_i=1 → 0x7 consumed, main=0x8, count_o stays 1.
- Saturation: CNT_W=3, hold a valid beat stalled 10 cycles → stall_cnt_o stops at 7.
